uart_tx_arbiter: RTL and testbench

Round-robin packet arbiter that shares the single UART transmit path between up to eight byte-stream requesters (debug module responses, status reporter, etc.). It sits directly in front of the UART interface's TX FIFO write port (WE/DSEND/TX_READY) and grants the path to one requester for a whole packet, so bytes from different sources never interleave on the wire.

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter in front of the UART TX FIFO
// write port. One requester owns the TX path for a whole packet, so bytes
// from different sources never interleave on the wire.
//
// Optional feature, macro UART_ARB_TIMEOUT_EN: when defined, an owner that
// stays idle (valid low) for TIMEOUT_CYCLES consecutive cycles mid-packet
// loses its grant, with a one-cycle ABORT_O pulse. When undefined, the grant
// is held until the LAST byte is transferred or reset; ABORT_O is tied to 0.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [NUM_REQ-1:0]     REQ_VALID_I,
  input  logic [NUM_REQ-1:0]     REQ_LAST_I,
  input  logic [8*NUM_REQ-1:0]   REQ_DATA_I,
  output logic [NUM_REQ-1:0]     REQ_READY_O,
  output logic [NUM_REQ-1:0]     GRANT_O,
  output logic [NUM_REQ-1:0]     ABORT_O,
  input  logic                   TX_READY_I,
  output logic                   WE_O,
  output logic [7:0]             DSEND_O
);

  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject unsupported configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic [OW-1:0]        r_owner;
  logic [OW-1:0]        r_last;
  logic [NUM_REQ-1:0]   r_grant;

  logic                 w_found;
  logic [OW-1:0]        w_winner;
  logic [4:0]           w_idx;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic                 w_owner_valid;
  logic                 w_owner_last;
  logic [7:0]           w_data;
  logic                 w_we;

  // Round-robin search: first valid requester at or above last-winner + 1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = 5'(r_last) + 5'(i) + 5'd1;
      if (w_idx >= 5'(NUM_REQ)) begin
        w_idx = w_idx - 5'(NUM_REQ);
      end
      if (!w_found && REQ_VALID_I[w_idx[OW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[OW-1:0];
      end
    end
  end

  assign w_win_onehot = NUM_REQ'(1) << w_winner;

  // Owner-side mux driven by the registered one-hot grant; r_grant is zero
  // in IDLE, so nothing from the inputs reaches the outputs there.
  always_comb begin
    w_data        = '0;
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_data        = w_data | REQ_DATA_I[8*i +: 8];
        w_owner_valid = w_owner_valid | REQ_VALID_I[i];
        w_owner_last  = w_owner_last | REQ_LAST_I[i];
      end
    end
  end

  assign w_we        = w_owner_valid & TX_READY_I;
  assign WE_O        = w_we;
  assign DSEND_O     = w_data;
  assign GRANT_O     = r_grant;
  assign REQ_READY_O = r_grant & {NUM_REQ{TX_READY_I}};

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] r_tcnt;
  logic          w_timeout;

  // Counter holds the number of idle owner cycles already seen, so the
  // TIMEOUT_CYCLES-th idle cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign w_timeout = (r_state == BUSY) && !w_owner_valid &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign ABORT_O   = w_timeout ? r_grant : '0;
`else
  assign ABORT_O   = '0;
`endif

  // Arbitration FSM: owner, grant and round-robin pointer.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= OW'(NUM_REQ - 1);
      r_grant <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
          r_tcnt <= '0;
`endif
          if (w_found) begin
            r_state <= BUSY;
            r_owner <= w_winner;
            r_grant <= w_win_onehot;
          end
        end
        BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
          if (w_owner_valid || w_timeout) begin
            r_tcnt <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
`endif
          if (w_we && w_owner_last) begin
            r_state <= IDLE;
            r_last  <= r_owner;
            r_grant <= '0;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= IDLE;
            r_last  <= r_owner;
            r_grant <= '0;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected writes are queued when
// packets are issued; a monitor pops one entry per WE_O cycle.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tx_ready = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ready;
  logic [N-1:0]   grant;
  logic [N-1:0]   abort;
  logic           we;
  logic [7:0]     dsend;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .REQ_VALID_I(req_valid),
    .REQ_LAST_I(req_last),
    .REQ_DATA_I(req_data),
    .REQ_READY_O(ready),
    .GRANT_O(grant),
    .ABORT_O(abort),
    .TX_READY_I(tx_ready),
    .WE_O(we),
    .DSEND_O(dsend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [7:0]   data;
    int           gap;   // cycles since previous write, 0 = don't care
  } exp_t;

  exp_t        sb[$];
  logic [8:0]  rq0[$];
  logic [8:0]  rq1[$];
  logic [N-1:0] hs = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: pop accepted byte, present the head of each queue.
  always @(posedge clk) begin
    logic [8:0] junk;
    #1;
    if (hs[0] && rq0.size() > 0) junk = rq0.pop_front();
    if (hs[1] && rq1.size() > 0) junk = rq1.pop_front();
    req_valid[0] = (rq0.size() > 0);
    {req_last[0], req_data[7:0]} = (rq0.size() > 0) ? rq0[0] : 9'h000;
    req_valid[1] = (rq1.size() > 0);
    {req_last[1], req_data[15:8]} = (rq1.size() > 0) ? rq1[0] : 9'h000;
  end

  // Monitor: handshake relations every cycle, scoreboard pop on each write.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hs = '0;
    end else begin
      hs = req_valid & ready;
      checks++;
      if (ready !== (grant & {N{tx_ready}}) ||
          we !== ((|(req_valid & grant)) & tx_ready) ||
          $countones(grant) > 1) begin
        errors++;
        $display("FAIL handshake @%0d: ready=%b we=%b grant=%b, required ready=%b we=%b onehot grant",
                 cyc, ready, we, grant, grant & {N{tx_ready}},
                 (|(req_valid & grant)) & tx_ready);
      end
      if (we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL write @%0d: unexpected write grant=%b data=%h, required no write",
                   cyc, grant, dsend);
        end else begin
          e = sb.pop_front();
          if (dsend !== e.data || grant !== e.grant ||
              (e.gap != 0 && (cyc - last_we) != e.gap)) begin
            errors++;
            $display("FAIL write @%0d: got grant=%b data=%h gap=%0d, required grant=%b data=%h gap=%0d",
                     cyc, grant, dsend, cyc - last_we, e.grant, e.data, e.gap);
          end
        end
        last_we = cyc;
      end
    end
  end

  task automatic add(input int r, input logic last, input logic [7:0] d);
    if (r == 0) rq0.push_back({last, d});
    else        rq1.push_back({last, d});
  endtask

  task automatic expect_w(input logic [N-1:0] g, input logic [7:0] d, input int gap);
    exp_t e;
    e.grant = g;
    e.data  = d;
    e.gap   = gap;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_we(input string name);
    int k = 0;
    while (we !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, we}, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((sb.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || grant != '0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " grant"}, grant, 0);
    check({tag, " ready"}, ready, 0);
    check({tag, " we"}, we, 0);
    check({tag, " dsend"}, dsend, 0);
    check({tag, " abort"}, abort, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Single requester, 3-byte packet, grant one cycle after request
    add(0, 1'b0, 8'h41); add(0, 1'b0, 8'h42); add(0, 1'b1, 8'h43);
    expect_w(2'b01, 8'h41, 0);
    expect_w(2'b01, 8'h42, 1);
    expect_w(2'b01, 8'h43, 1);
    @(negedge clk);
    check("t1 idle grant", grant, 0);
    check("t1 idle we", we, 0);
    check("t1 idle ready", ready, 0);
    @(negedge clk);
    check("t1 grant", grant, 2'b01);
    wait_drain("t1 drain");

    // Contention from reset: alternation with one dead cycle between packets
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    add(0, 1'b0, 8'hA1); add(0, 1'b1, 8'hA2); add(0, 1'b0, 8'hA3); add(0, 1'b1, 8'hA4);
    add(1, 1'b0, 8'hB1); add(1, 1'b1, 8'hB2); add(1, 1'b0, 8'hB3); add(1, 1'b1, 8'hB4);
    expect_w(2'b01, 8'hA1, 0); expect_w(2'b01, 8'hA2, 1);
    expect_w(2'b10, 8'hB1, 2); expect_w(2'b10, 8'hB2, 1);
    expect_w(2'b01, 8'hA3, 2); expect_w(2'b01, 8'hA4, 1);
    expect_w(2'b10, 8'hB3, 2); expect_w(2'b10, 8'hB4, 1);
    wait_drain("t2 drain");

    // Backpressure: 5 stalled cycles after the first byte
    add(0, 1'b0, 8'h51); add(0, 1'b0, 8'h52); add(0, 1'b1, 8'h53);
    expect_w(2'b01, 8'h51, 0);
    expect_w(2'b01, 8'h52, 6);
    expect_w(2'b01, 8'h53, 1);
    wait_we("t3 first write");
    @(posedge clk);
    #1 tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3 stall we", we, 0);
      check("t3 stall ready", ready, 0);
      check("t3 stall grant", grant, 2'b01);
      check("t3 stall dsend", dsend, 8'h52);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain("t3 drain");

    // No interleave: req1 arrives mid-packet of req0
    add(0, 1'b0, 8'h61); add(0, 1'b0, 8'h62); add(0, 1'b1, 8'h63);
    expect_w(2'b01, 8'h61, 0); expect_w(2'b01, 8'h62, 1); expect_w(2'b01, 8'h63, 1);
    expect_w(2'b10, 8'h71, 2);
    wait_we("t4 first write");
    add(1, 1'b1, 8'h71);
    begin
      int k = 0;
      while (grant == 2'b01 && k < 20) begin
        check("t4 req1 ready held", ready[1], 0);
        @(negedge clk);
        k++;
      end
    end
    wait_drain("t4 drain");

    // Reset mid-packet: pointer returns to favour req0
    add(0, 1'b1, 8'hC0);
    expect_w(2'b01, 8'hC0, 0);
    wait_drain("t5 pre drain");
    add(1, 1'b0, 8'h81); add(1, 1'b0, 8'h82); add(1, 1'b1, 8'h83);
    expect_w(2'b10, 8'h81, 0);
    wait_we("t5 first write");
    @(posedge clk);
    #2 rst = 1'b1;
    rq1.delete();
    #1 check_zero("t5 reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    add(0, 1'b1, 8'h91);
    add(1, 1'b1, 8'hE1);
    expect_w(2'b01, 8'h91, 0);
    expect_w(2'b10, 8'hE1, 2);
    wait_drain("t5 drain");

`ifdef UART_ARB_TIMEOUT_EN
    // Timeout: owner goes quiet after one byte
    add(0, 1'b0, 8'hD1);
    add(1, 1'b1, 8'hE2);
    expect_w(2'b01, 8'hD1, 0);
    expect_w(2'b10, 8'hE2, 10);
    wait_we("t6 first write");
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check($sformatf("t6 abort idle%0d", j), abort, (j == 8) ? 2'b01 : 2'b00);
      check($sformatf("t6 grant idle%0d", j), grant, 2'b01);
    end
    wait_drain("t6 drain");
`else
    // Without timeout the quiet owner keeps the grant
    add(0, 1'b0, 8'hD1);
    add(1, 1'b1, 8'hE2);
    expect_w(2'b01, 8'hD1, 0);
    wait_we("t6 first write");
    repeat (12) begin
      @(negedge clk);
      check("t6 grant held", grant, 2'b01);
      check("t6 no abort", abort, 0);
    end
    add(0, 1'b1, 8'hD2);
    expect_w(2'b01, 8'hD2, 0);
    expect_w(2'b10, 8'hE2, 2);
    wait_drain("t6 drain");
`endif

    check("final scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
